dpram_arbiter: RTL

DPRAM_ARBITER -- requirements
Module: dpram_arbiter

---
 rtl/dpram_arbiter_pkg.sv | 15 +
 rtl/dpram_arbiter_rr_arbiter.sv | 35 +++
 rtl/dpram_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/dpram_arbiter_pkg.sv
// Shared types and constants for the dual-port RAM arbiter.
package dpram_arb_pkg;

   localparam int unsigned LOCK_TIMEOUT = 16;

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   function automatic int unsigned ptr_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dpram_arbiter_rr_arbiter.sv
// Round-robin grant: first active request at or after the priority pointer wins.
module rr_arbiter
   import dpram_arb_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned PW   = 2
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [PW-1:0]   i_ptr,
   output logic [NREQ-1:0] o_grant,
   output logic [PW-1:0]   o_winner,
   output logic            o_any
);

   int unsigned w_idx;

   always_comb begin
      o_grant  = '0;
      o_winner = '0;
      o_any    = 1'b0;
      w_idx    = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         w_idx = 32'(i_ptr) + k;
         if (w_idx >= NREQ) begin
            w_idx = w_idx - NREQ;
         end
         if (!o_any && i_req[w_idx]) begin
            o_grant[w_idx] = 1'b1;
            o_winner       = PW'(w_idx);
            o_any          = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dpram_arbiter.sv
// Shares one RAM port among NREQ requesters with zero-latency round-robin grant.
// Define DPRAM_ARB_LOCK_EN to add the req_lock port and ARB/LOCKED bus locking.
module dpram_arbiter
   import dpram_arb_pkg::*;
#(
   parameter int unsigned NREQ   = 4,
   parameter int unsigned DWIDTH = 16,
   parameter int unsigned AWIDTH = 10,
   parameter int unsigned RD_LAT = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ-1:0]        req_we,
   input  logic [NREQ*AWIDTH-1:0] req_addr,
   input  logic [NREQ*DWIDTH-1:0] req_data,
`ifdef DPRAM_ARB_LOCK_EN
   input  logic [NREQ-1:0]        req_lock,
`endif
   output logic [NREQ-1:0]        rsp_valid,
   output logic [DWIDTH-1:0]      rsp_data,
   output logic                   mem_we,
   output logic [AWIDTH-1:0]      mem_addr,
   output logic [DWIDTH-1:0]      mem_data,
   input  logic [DWIDTH-1:0]      mem_q
);

   localparam int unsigned PW = ptr_width(NREQ);

   logic [PW-1:0]     r_ptr;
   logic [PW-1:0]     w_ptr_nxt;
   logic [NREQ-1:0]   w_req;
   logic [NREQ-1:0]   w_grant;
   logic [PW-1:0]     w_winner;
   logic [PW-1:0]     w_win_inc;
   logic              w_any;
   logic              w_xfer;
   logic              w_win_we;
   logic [AWIDTH-1:0] w_addr_arr [NREQ];
   logic [DWIDTH-1:0] w_data_arr [NREQ];
   logic [AWIDTH-1:0] r_addr_hold;
   logic [DWIDTH-1:0] r_data_hold;
   logic [NREQ-1:0]   w_rd_tag;

   always_comb begin
      for (int unsigned k = 0; k < NREQ; k++) begin
         w_addr_arr[k] = req_addr[k*AWIDTH +: AWIDTH];
         w_data_arr[k] = req_data[k*DWIDTH +: DWIDTH];
      end
   end

   rr_arbiter #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_rr (
      .i_req    (w_req),
      .i_ptr    (r_ptr),
      .o_grant  (w_grant),
      .o_winner (w_winner),
      .o_any    (w_any)
   );

   always_comb begin
      w_xfer    = w_any & ~rst;
      w_win_we  = req_we[w_winner];
      w_win_inc = (w_winner == PW'(NREQ - 1)) ? '0 : w_winner + 1'b1;
      req_ready = w_xfer ? w_grant : '0;
      mem_we    = w_xfer & w_win_we;
      mem_addr  = w_xfer ? w_addr_arr[w_winner] : r_addr_hold;
      mem_data  = w_xfer ? w_data_arr[w_winner] : r_data_hold;
      w_rd_tag  = (w_xfer && !w_win_we) ? w_grant : '0;
      rsp_data  = mem_q;
   end

`ifdef DPRAM_ARB_LOCK_EN
   localparam int unsigned TW = $clog2(LOCK_TIMEOUT) + 1;

   arb_state_t    r_state;
   arb_state_t    w_state_nxt;
   logic [PW-1:0] r_owner;
   logic [PW-1:0] w_owner_nxt;
   logic [PW-1:0] w_own_inc;
   logic [TW-1:0] r_idle;
   logic [TW-1:0] w_idle_nxt;

   // While locked only the owner's request reaches the round-robin core.
   always_comb begin
      w_own_inc = (r_owner == PW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
      w_req     = (r_state == LOCKED) ? (req_valid & (NREQ'(1) << r_owner)) : req_valid;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_idle_nxt  = r_idle;
      w_ptr_nxt   = w_xfer ? w_win_inc : r_ptr;
      unique case (r_state)
         ARB: begin
            if (w_xfer && req_lock[w_winner]) begin
               w_state_nxt = LOCKED;
               w_owner_nxt = w_winner;
               w_idle_nxt  = '0;
            end
         end
         LOCKED: begin
            if (w_xfer) begin
               w_idle_nxt = '0;
               if (!req_lock[w_winner]) begin
                  w_state_nxt = ARB;
               end
            end else if (!req_valid[r_owner]) begin
               if (r_idle == TW'(LOCK_TIMEOUT - 1)) begin
                  w_state_nxt = ARB;
                  w_idle_nxt  = '0;
                  w_ptr_nxt   = w_own_inc;
               end else begin
                  w_idle_nxt = r_idle + 1'b1;
               end
            end else begin
               w_idle_nxt = '0;
            end
         end
         default: w_state_nxt = ARB;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ARB;
         r_owner <= '0;
         r_idle  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_owner <= w_owner_nxt;
         r_idle  <= w_idle_nxt;
      end
   end
`else
   always_comb begin
      w_req     = req_valid;
      w_ptr_nxt = w_xfer ? w_win_inc : r_ptr;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr       <= '0;
         r_addr_hold <= '0;
         r_data_hold <= '0;
      end else begin
         r_ptr <= w_ptr_nxt;
         if (w_xfer) begin
            r_addr_hold <= w_addr_arr[w_winner];
            r_data_hold <= w_data_arr[w_winner];
         end
      end
   end

   // One-hot read tags travel alongside the RAM latency; writes insert zero.
   generate
      if (RD_LAT == 0) begin : g_lat0
         always_comb rsp_valid = w_rd_tag;
      end else begin : g_pipe
         logic [NREQ-1:0] r_tag [RD_LAT];

         always_ff @(posedge clk) begin
            if (rst) begin
               for (int unsigned k = 0; k < RD_LAT; k++) begin
                  r_tag[k] <= '0;
               end
            end else begin
               r_tag[0] <= w_rd_tag;
               for (int unsigned k = 1; k < RD_LAT; k++) begin
                  r_tag[k] <= r_tag[k-1];
               end
            end
         end

         always_comb rsp_valid = rst ? '0 : r_tag[RD_LAT-1];
      end
   endgenerate

endmodule
